// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, master state set and UART register map shared by the load/store master.
package lsu_pkg;
  localparam logic [2:0] F3_B = 3'd0;
  localparam logic [2:0] F3_H = 3'd1;
  localparam logic [2:0] F3_W = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [31:0] UART_STATUS = 32'h0000_0200;
  localparam logic [31:0] UART_TX = 32'h0000_0201;
  localparam logic [31:0] UART_RX = 32'h0000_0202;
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} lsuState_t;
  function automatic logic isIllegal(input logic [2:0] funct3, input logic write, input logic [1:0] addrLo);
    return (funct3 == 3'd3) || (funct3[2:1] == 2'b11) || (funct3[2] && write) ||
           (funct3[1:0] == 2'd1 && addrLo[0]) || (funct3[1:0] == 2'd2 && addrLo != 2'd0);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane placement of store data/enables and lane extraction with extension for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  input  logic [31:0] q,
  output logic [31:0] storeData,
  output logic [3:0]  storeBen,
  output logic [31:0] loadData
);
  logic [7:0] laneB;
  logic [15:0] laneH;
  always_comb begin
    storeData = wdata << {addrLo, 3'b000};
    storeBen = (funct3[1:0] == 2'd0 ? 4'b0001 : funct3[1:0] == 2'd1 ? 4'b0011 : 4'b1111) << addrLo;
    laneB = q[{addrLo, 3'b000} +: 8];
    laneH = q[{addrLo[1], 4'b0000} +: 16];
    loadData = funct3 == F3_B  ? {{24{laneB[7]}}, laneB} :
               funct3 == F3_H  ? {{16{laneH[15]}}, laneH} :
               funct3 == F3_BU ? {24'd0, laneB} :
               funct3 == F3_HU ? {16'd0, laneH} : q;
  end
endmodule

// File: rtl/load_store_master.sv
// load_store_master: issues one RV32 load/store at a time onto the memory-map bus and returns the aligned result.
module load_store_master
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] vaddr,
  output logic [31:0] data,
  output logic [3:0]  byteena,
  output logic        memWE,
  input  logic        memWait,
  input  logic [31:0] q
);
  // The UART responds to address alone, so never park on one of its registers.
  localparam logic [31:0] PARK = (IDLE_ADDR inside {UART_STATUS, UART_TX, UART_RX}) ? 32'h0 : IDLE_ADDR;
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  lsuState_t state, nextState;
  logic [2:0] funct3Q, cnt, alignF3;
  logic [1:0] addrLoQ, alignLo;
  logic accept, illegal, latDone;
  logic [31:0] storeData, loadData;
  logic [3:0] storeBen;
  always_comb begin
    accept = req_valid && state == IDLE;
    illegal = isIllegal(req_funct3, req_write, req_addr[1:0]);
    latDone = !memWait && cnt == LAT;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    alignF3 = state == IDLE ? req_funct3 : funct3Q;
    alignLo = state == IDLE ? req_addr[1:0] : addrLoQ;
    nextState = state;
    case (state)
      IDLE:  nextState = !accept ? IDLE : illegal ? RESP : req_write ? WRITE : READ;
      WRITE: nextState = memWait ? WRITE : RESP;
      READ:  nextState = latDone ? RESP : READ;
      default: nextState = IDLE;
    endcase
  end
  lsu_lane_align align (
    .funct3(alignF3),
    .addrLo(alignLo),
    .wdata(req_wdata),
    .q(q),
    .storeData(storeData),
    .storeBen(storeBen),
    .loadData(loadData)
  );
  always_ff @(posedge clock or posedge RST)
    if (RST) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      vaddr <= PARK;
      data <= '0;
      byteena <= '0;
      memWE <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      cnt <= '0;
      funct3Q <= '0;
      addrLoQ <= '0;
    end else if (accept) begin
      funct3Q <= req_funct3;
      addrLoQ <= req_addr[1:0];
      cnt <= 3'd1;
      if (illegal) begin
        resp_err <= 1'b1;
        resp_rdata <= '0;
      end else begin
        vaddr <= req_addr;
        memWE <= req_write;
        byteena <= req_write ? storeBen : 4'b0000;
        if (req_write) data <= storeData;
      end
    end else if (state == WRITE && !memWait) begin
      vaddr <= PARK;
      memWE <= 1'b0;
      byteena <= '0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
    end else if (state == READ && !memWait) begin
      cnt <= cnt + 3'd1;
      if (latDone) begin
        vaddr <= PARK;
        resp_err <= 1'b0;
        resp_rdata <= loadData;
      end
    end
  end
endmodule

// File: tb/tb_load_store_master.sv
// tb_load_store_master: directed and randomized transactions checked against a transaction-level model.
module tb_load_store_master;
  localparam int RL = 2;
  logic clock = 1'b0;
  logic RST = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, memWait = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, q = '0;
  logic req_ready, resp_valid, resp_err, memWE;
  logic [31:0] resp_rdata, vaddr, data;
  logic [3:0] byteena;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  load_store_master #(.READ_LATENCY(RL), .IDLE_ADDR(32'h0)) dut (
    .clock(clock), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .vaddr(vaddr), .data(data), .byteena(byteena), .memWE(memWE),
    .memWait(memWait), .q(q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int lo, input logic [31:0] qv);
    logic [31:0] s;
    s = qv >> (8 * lo);
    case (f3)
      3'd0: return 32'($signed(s[7:0]));
      3'd1: return 32'($signed(s[15:0]));
      3'd4: return {24'd0, s[7:0]};
      3'd5: return {16'd0, s[15:0]};
      default: return qv;
    endcase
  endfunction

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] qFixed, input logic randQ, input int stallAt, input int stallLen);
    int lo, bytes, n, left, t;
    logic err, done;
    logic [31:0] src, expRd, expData;
    logic [3:0] expBen;
    lo = int'(addr[1:0]);
    bytes = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    err = (f3 == 3'd3) || (f3 >= 3'd6) || (w && f3 >= 3'd4) || (lo % bytes != 0);
    expData = wd << (8 * lo);
    expBen = 4'(((1 << bytes) - 1) << lo);
    src = '0;
    @(negedge clock);
    check("ready", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    memWait = 1'($urandom_range(0, 1));
    q = $urandom;
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 0; left = stallLen; done = err; t = 0;
    while (!done && t < 40) begin
      check("bus_vaddr", vaddr, addr);
      check("bus_we", memWE, w);
      check("bus_ben", byteena, w ? expBen : 4'b0000);
      if (w) check("bus_data", data, expData);
      check("busy_valid", resp_valid, 0);
      check("busy_ready", req_ready, 0);
      memWait = (n == stallAt && left > 0);
      if (memWait) left--;
      q = randQ ? $urandom : qFixed;
      if (!memWait) begin
        n++;
        if (w ? n == 1 : n == RL) begin
          done = 1'b1;
          src = q;
        end
      end
      t++;
      @(negedge clock);
    end
    if (!done) check("timeout", 1, 0);
    expRd = (err || w) ? 32'h0 : modelLoad(f3, lo, src);
    memWait = 1'($urandom_range(0, 1));
    q = $urandom;
    check("resp_valid", resp_valid, 1);
    check("resp_err", resp_err, err);
    check("resp_rdata", resp_rdata, expRd);
    check("park_vaddr", vaddr, 32'h0);
    check("park_we", memWE, 0);
    check("park_ben", byteena, 0);
    check("resp_ready", req_ready, 0);
    @(negedge clock);
    memWait = 1'b0;
    check("after_valid", resp_valid, 0);
    check("hold_rdata", resp_rdata, expRd);
    check("hold_err", resp_err, err);
  endtask

  initial begin
    #1 RST = 1'b1;
    #1;
    check("rst_vaddr", vaddr, 0);
    check("rst_data", data, 0);
    check("rst_ben", byteena, 0);
    check("rst_we", memWE, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_err", resp_err, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_ready", req_ready, 1);
    repeat (2) @(negedge clock);
    RST = 1'b0;

    txn(1, 3'd2, 32'h40, 32'hDEADBEEF, 0, 1, 0, 0);
    txn(1, 3'd0, 32'h43, 32'h000000A5, 0, 1, 1, 0);
    check("sb_data_last", data, 32'hA5000000);
    txn(0, 3'd0, 32'h43, 0, 32'hA5000000, 0, 0, 0);
    check("lb_const", resp_rdata, 32'hFFFFFFA5);
    txn(0, 3'd4, 32'h43, 0, 32'hA5000000, 0, 0, 0);
    check("lbu_const", resp_rdata, 32'h000000A5);
    txn(0, 3'd1, 32'h42, 0, 32'h80010000, 0, 0, 0);
    check("lh_const", resp_rdata, 32'hFFFF8001);
    txn(0, 3'd5, 32'h42, 0, 32'h80010000, 0, 0, 0);
    check("lhu_const", resp_rdata, 32'h00008001);
    txn(0, 3'd2, 32'h46, 0, 0, 1, 0, 0);
    check("lw_mis_err", resp_err, 1);
    txn(0, 3'd3, 32'h40, 0, 0, 1, 0, 0);
    check("f3_3_err", resp_err, 1);
    txn(0, 3'd2, 32'h80, 0, 32'h12345678, 0, 1, 3);
    check("lw_stall", resp_rdata, 32'h12345678);
    txn(1, 3'd0, 32'h201, 32'h41, 0, 1, 0, 0);
    txn(1, 3'd2, 32'h44, 32'hCAFEF00D, 0, 1, 0, 2);

    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
    @(negedge clock);
    req_valid = 1'b0;
    check("rst_mid_vaddr", vaddr, 32'h80);
    #2 RST = 1'b1;
    #1;
    check("arst_vaddr", vaddr, 0);
    check("arst_ben", byteena, 0);
    check("arst_we", memWE, 0);
    check("arst_valid", resp_valid, 0);
    check("arst_ready", req_ready, 1);
    @(negedge clock);
    RST = 1'b0;
    repeat (RL + 2) begin
      @(negedge clock);
      check("arst_no_resp", resp_valid, 0);
    end
    check("arst_ready_after", req_ready, 1);

    for (int i = 0; i < 150; i++) begin
      logic w;
      logic [2:0] f3;
      logic [31:0] a;
      w = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~(f3[1:0] == 2'd0 ? 32'h0 : f3[1:0] == 2'd1 ? 32'h1 : 32'h3);
      txn(w, f3, a, $urandom, 0, 1, $urandom_range(0, RL - 1), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_master.md
Name: load_store_master

Overview:
- Initiator side of the CPU-to-memory-map interface.
- Accepts one RV32 load/store from the core at a time and turns it into a bus access on vaddr/data/byteena/memWE.
- Honours memWait, waits out the fixed read latency, then returns an aligned, sign- or zero-extended result.
- Sits between the execute stage and the memory-map/MMU responder (RAM plus UART registers at 0x200–0x202).

Parameters:
- READ_LATENCY, 2: clock cycles from the first cycle vaddr is driven to the cycle q is sampled (legal range 1–7).
- IDLE_ADDR, 32'h0000_0000: address parked on vaddr when no access is active. Must not fall in 0x200–0x202.

Ports:
- clock  in  1  system clock
- RST  in  1  asynchronous active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  high when a request can be accepted
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  misaligned access or illegal funct3; qualified by resp_valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- vaddr  out  32  bus address
- data  out  32  lane-shifted store data
- byteena  out  4  byte lanes
- memWE  out  1  write enable
- memWait  in  1  responder stall
- q  in  32  responder read data

Behaviour:
- Reset: state IDLE, vaddr=IDLE_ADDR, data=0, byteena=0, memWE=0, resp_valid=0, resp_err=0, resp_rdata=0, latency counter=0. Reset mid-access aborts it immediately; no response is issued.
- req_ready = (state==IDLE). A request is accepted on a clock edge where req_valid && req_ready. All request fields are captured at that edge.
- States: IDLE, WRITE, READ, RESP.
- IDLE, on accept:
  - Misaligned request (halfword with addr[0]=1; word with addr[1:0]!=0) or funct3 in {3,6,7}, or funct3 in {4,5} with req_write=1: go to RESP with resp_err=1. No bus activity occurs.
  - Store: go to WRITE. Next cycle drives vaddr=req_addr; data=req_wdata shifted left by 8*addr[1:0]; byteena = 0001, 0011 or 1111 shifted left by addr[1:0]; memWE=1.
  - Load: go to READ. Next cycle drives vaddr=req_addr, byteena=0, memWE=0, counter=1.
- WRITE: lasts exactly one non-stalled cycle, then goes to RESP with vaddr=IDLE_ADDR, memWE=0, byteena=0. vaddr is never left on a UART address because the responder acts on address alone.
- READ: each non-stalled cycle, counter increments. When counter==READ_LATENCY:
  - Sample q and select the lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Load resp_rdata, park vaddr at IDLE_ADDR, go to RESP.
- memWait=1 in WRITE or READ: all bus outputs hold their values, the counter freezes, and no state change occurs.
  - memWait is ignored in IDLE and RESP.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. resp_rdata and resp_err hold until the next response.
- Throughput: a request cannot be accepted in the RESP cycle. Back-to-back access:
  - store: 3 cycles (accept, bus, resp);
  - load: 2+READ_LATENCY cycles.
- req_valid while not ready: ignored. The core must hold the request.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5);
  - state enum;
  - UART address constants (UART_STATUS=0x200, UART_TX=0x201, UART_RX=0x202).
- Sub-module lsu_lane_align (combinational): store shift/byteena generation and load extraction/extension. Verified standalone.

Test Plan:
- SW addr=0x40, wdata=0xDEADBEEF -> one cycle with vaddr=0x40, byteena=1111, memWE=1, data=0xDEADBEEF; then resp_valid=1, resp_err=0; vaddr returns to 0x0.
- SB addr=0x43, wdata=0x000000A5 -> data=0xA5000000, byteena=1000. LB at 0x43 with q=0xA5000000 -> resp_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr=0x42, q=0x80010000, READ_LATENCY=2 -> q sampled exactly 2 cycles after vaddr=0x42 first driven; resp_rdata=0xFFFF8001. LHU -> 0x00008001.
- LW addr=0x46 -> resp_valid with resp_err=1 the cycle after accept; memWE, byteena and vaddr never leave their idle values. funct3=3 behaves the same.
- LW addr=0x80 with memWait held high for 3 cycles mid-read -> vaddr held at 0x80, response delayed by exactly 3 cycles, data correct.
- SB addr=0x201, wdata=0x41 -> vaddr=0x201 for exactly one cycle. RST asserted during a READ -> outputs return to reset values asynchronously, no resp_valid, req_ready=1 after release.
